// File: rtl/pci_emu_pkg.sv
// Shared definitions for the PCI target burst emulator:
// command codes, register offsets, scratch-pad window, fill word, FSM states.
package pci_emu_pkg;

  localparam logic [3:0] CMD_MRD = 4'h1;
  localparam logic [3:0] CMD_MWR = 4'h2;
  localparam logic [3:0] CMD_DRD = 4'h4;
  localparam logic [3:0] CMD_DWR = 4'h8;

  localparam logic [31:0] REG_GPDDR = 32'h000;
  localparam logic [31:0] REG_GPDR  = 32'h004;
  localparam logic [31:0] REG_CKISR = 32'h008;
  localparam logic [31:0] REG_STAT  = 32'h00C;

  // Window is sized for the largest pad; smaller pads alias inside it.
  localparam logic [31:0] SP_BASE = 32'h100;
  localparam logic [31:0] SP_SPAN = 32'h400;

  localparam logic [31:0] FILL_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOD,
    ST_DEV_REQ,
    ST_DEV_XFER
  } state_e;

  function automatic logic is_rd(input logic [3:0] c);
    return (c == CMD_MRD) || (c == CMD_DRD);
  endfunction

endpackage

// File: rtl/pci_emu_sp_ram.sv
// Scratch pad: WORDS x 32, synchronous write, asynchronous read.
// Ports: clk_i, we_i, addr_i (shared r/w index), wdata_i, rdata_o.
module pci_emu_sp_ram #(
  parameter int WORDS = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pci_emu_target_burst.sv
// PCI target emulator: burst module/device cycles, regs, scratch pad, GPIO.
// Ports: PCI_* bus side (AD/GPIO tri-state), OPB_* device side, OPB_RST reset.
module pci_emu_target_burst
  import pci_emu_pkg::*;
#(
  parameter int GPIO_W   = 7,
  parameter int CKI_W    = 2,
  parameter int SP_WORDS = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic              PCI_CLK2,
  input  logic              OPB_RST,
  inout  wire  [31:0]       PCI_AD,
  input  logic [3:0]        PCI_CBE,
  input  logic              PCI_FRAME,
  input  logic              PCI_DEVSEL,
  input  logic              PCI_IRDY,
  output logic              PCI_TRDY,
  input  logic [CKI_W-1:0]  PCI_CKI,
  inout  wire  [GPIO_W-1:0] PCI_GPIO,
  input  logic [31:0]       OPB_DO,
  input  logic              OPB_ACK,
  output logic [31:0]       OPB_DI,
  output logic [31:0]       OPB_ADDR,
  output logic              OPB_RE,
  output logic              OPB_WE
);

  localparam int AW = $clog2(SP_WORDS);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e            state_q;
  logic [3:0]        cmd_q;
  logic [31:0]       addr_q;
  logic [31:0]       rd_q;
  logic [15:0]       wait_q;
  logic [GPIO_W-1:0] gpddr_q;
  logic [GPIO_W-1:0] gpdr_q;
  logic              to_q;
  logic [7:0]        cnt_q;
  logic [7:0]        last_cnt_q;
  logic              trdy_q;

  logic              sel_ddr;
  logic              sel_dr;
  logic              sel_cki;
  logic              sel_stat;
  logic              sp_hit;
  logic [AW-1:0]     sp_idx;
  logic [31:0]       sp_rdata;
  logic              sp_we;
  logic [31:0]       mod_rdata;
  logic [7:0]        cnt_inc;
  logic              abort;
  logic              ad_oe;
  logic [31:0]       ad_out;

  always_comb begin
    sel_ddr  = addr_q[31:2] == REG_GPDDR[31:2];
    sel_dr   = addr_q[31:2] == REG_GPDR[31:2];
    sel_cki  = addr_q[31:2] == REG_CKISR[31:2];
    sel_stat = addr_q[31:2] == REG_STAT[31:2];
    sp_hit   = (addr_q >= SP_BASE) && (addr_q < SP_BASE + SP_SPAN);
    sp_idx   = AW'((addr_q - SP_BASE) >> 2);
  end

  always_comb begin
    mod_rdata = '0;
    unique case (1'b1)
      sel_ddr:  mod_rdata = 32'(gpddr_q);
      sel_dr:   mod_rdata = 32'(PCI_GPIO);
      sel_cki:  mod_rdata = 32'(PCI_CKI);
      sel_stat: mod_rdata = {16'h0, last_cnt_q, 7'h0, to_q};
      sp_hit:   mod_rdata = sp_rdata;
      default:  mod_rdata = '0;
    endcase
  end

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign abort   = (state_q != ST_IDLE) && PCI_FRAME && PCI_IRDY;

  assign sp_we = !OPB_RST && (state_q == ST_MOD) && !PCI_IRDY
               && (cmd_q == CMD_MWR) && sp_hit;

  pci_emu_sp_ram #(
    .WORDS (SP_WORDS),
    .AW    (AW)
  ) u_sp (
    .clk_i   (PCI_CLK2),
    .we_i    (sp_we),
    .addr_i  (sp_idx),
    .wdata_i (PCI_AD),
    .rdata_o (sp_rdata)
  );

  always_ff @(posedge PCI_CLK2) begin
    if (OPB_RST) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      rd_q       <= '0;
      wait_q     <= '0;
      gpddr_q    <= '0;
      gpdr_q     <= '0;
      to_q       <= 1'b0;
      cnt_q      <= '0;
      last_cnt_q <= '0;
      trdy_q     <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_q  <= '0;
          wait_q <= '0;
          if (!PCI_FRAME && !PCI_DEVSEL) begin
            if (PCI_CBE == CMD_MRD || PCI_CBE == CMD_MWR) begin
              state_q <= ST_MOD;
              trdy_q  <= 1'b0;
              addr_q  <= PCI_AD;
              cmd_q   <= PCI_CBE;
            end else if (PCI_CBE == CMD_DRD || PCI_CBE == CMD_DWR) begin
              state_q <= ST_DEV_REQ;
              addr_q  <= PCI_AD;
              cmd_q   <= PCI_CBE;
            end
          end
        end
        ST_MOD: begin
          if (abort) begin
            state_q <= ST_IDLE;
            trdy_q  <= 1'b1;
          end else if (!PCI_IRDY) begin
            if (cmd_q == CMD_MWR) begin
              if (sel_ddr) gpddr_q <= PCI_AD[GPIO_W-1:0];
              if (sel_dr) gpdr_q <= PCI_AD[GPIO_W-1:0];
              if (sel_stat && PCI_AD[0]) to_q <= 1'b0;
            end
            addr_q <= addr_q + 32'd4;
            cnt_q  <= cnt_inc;
            if (PCI_FRAME) begin
              state_q    <= ST_IDLE;
              trdy_q     <= 1'b1;
              last_cnt_q <= cnt_inc;
            end
          end
        end
        ST_DEV_REQ: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (OPB_ACK) begin
            // ACK outranks a timeout landing on the same edge.
            state_q <= ST_DEV_XFER;
            trdy_q  <= 1'b0;
            if (cmd_q == CMD_DRD) rd_q <= OPB_DO;
          end else if (wait_q == TO_LAST) begin
            state_q <= ST_DEV_XFER;
            trdy_q  <= 1'b0;
            rd_q    <= FILL_WORD;
            to_q    <= 1'b1;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        ST_DEV_XFER: begin
          if (abort) begin
            state_q <= ST_IDLE;
            trdy_q  <= 1'b1;
          end else if (!PCI_IRDY) begin
            addr_q <= addr_q + 32'd4;
            cnt_q  <= cnt_inc;
            wait_q <= '0;
            trdy_q <= 1'b1;
            if (PCI_FRAME) begin
              state_q    <= ST_IDLE;
              last_cnt_q <= cnt_inc;
            end else begin
              state_q <= ST_DEV_REQ;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ad_oe  = is_rd(cmd_q)
                && (state_q == ST_MOD || state_q == ST_DEV_XFER);
  assign ad_out = (state_q == ST_MOD) ? mod_rdata : rd_q;
  assign PCI_AD = ad_oe ? ad_out : 32'bz;

  for (genvar i = 0; i < GPIO_W; i++) begin : g_gpio
    assign PCI_GPIO[i] = gpddr_q[i] ? gpdr_q[i] : 1'bz;
  end

  assign PCI_TRDY = trdy_q;
  assign OPB_ADDR = addr_q;
  assign OPB_DI   = PCI_AD;
  assign OPB_RE   = (state_q == ST_DEV_REQ) && (cmd_q == CMD_DRD);
  // Write strobe only while the initiator presents valid data.
  assign OPB_WE   = (state_q == ST_DEV_REQ) && (cmd_q == CMD_DWR)
                  && !PCI_IRDY;

endmodule

// File: tb/tb_pci_emu_target_burst.sv
// Self-checking bench for pci_emu_target_burst.
// Scoreboard queues: expected pushed with stimulus, observed popped per test.
module tb_pci_emu_target_burst;
  import pci_emu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cbe = '0;
  logic        frame = 1'b1;
  logic        devsel = 1'b1;
  logic        irdy = 1'b1;
  logic [1:0]  cki = 2'b10;
  logic [31:0] opb_do = '0;
  logic        opb_ack = 1'b0;
  logic        ad_oe = 1'b0;
  logic [31:0] ad_drv = '0;

  wire  [31:0] ad;
  wire  [6:0]  gpio;
  logic        trdy;
  logic [31:0] opb_di;
  logic [31:0] opb_addr;
  logic        opb_re;
  logic        opb_we;

  assign ad = ad_oe ? ad_drv : 32'bz;

  for (genvar i = 0; i < 32; i++) begin : g_pu
    pullup pu (ad[i]);
  end
  for (genvar i = 0; i < 7; i++) begin : g_pd
    pulldown pd (gpio[i]);
  end

  pci_emu_target_burst #(
    .GPIO_W   (7),
    .CKI_W    (2),
    .SP_WORDS (16),
    .TIMEOUT  (TO)
  ) dut (
    .PCI_CLK2   (clk),
    .OPB_RST    (rst),
    .PCI_AD     (ad),
    .PCI_CBE    (cbe),
    .PCI_FRAME  (frame),
    .PCI_DEVSEL (devsel),
    .PCI_IRDY   (irdy),
    .PCI_TRDY   (trdy),
    .PCI_CKI    (cki),
    .PCI_GPIO   (gpio),
    .OPB_DO     (opb_do),
    .OPB_ACK    (opb_ack),
    .OPB_DI     (opb_di),
    .OPB_ADDR   (opb_addr),
    .OPB_RE     (opb_re),
    .OPB_WE     (opb_we)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] wr_q[$];

  task automatic bus_idle();
    frame   = 1'b1;
    devsel  = 1'b1;
    irdy    = 1'b1;
    ad_oe   = 1'b0;
    cbe     = '0;
    opb_ack = 1'b0;
  endtask

  task automatic addr_phase(input logic [3:0] c, input logic [31:0] a);
    @(negedge clk);
    frame  = 1'b0;
    devsel = 1'b0;
    irdy   = 1'b1;
    cbe    = c;
    ad_oe  = 1'b1;
    ad_drv = a;
    @(posedge clk);
  endtask

  task automatic mod_burst(input logic [3:0] c, input logic [31:0] a,
                           input int n);
    addr_phase(c, a);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      irdy  = 1'b0;
      frame = (k == n - 1);
      if (c == CMD_MWR) begin
        ad_oe  = 1'b1;
        ad_drv = wr_q.pop_front();
      end else begin
        ad_oe = 1'b0;
      end
      #1;
      if (c == CMD_MRD) obs_q.push_back(ad);
      @(posedge clk);
    end
    @(negedge clk);
    bus_idle();
  endtask

  // Per phase pushes observed OPB_ADDR, wait cycles, and read data.
  task automatic dev_burst(input logic [3:0] c, input logic [31:0] a,
                           input int n, input bit ack_en, input int dly,
                           input logic [31:0] do_base);
    int  w;
    bit  done;
    bit  hung;
    hung = 1'b0;
    addr_phase(c, a);
    for (int k = 0; k < n && !hung; k++) begin
      w    = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        irdy  = 1'b0;
        frame = (k == n - 1);
        if (c == CMD_DWR) begin
          ad_oe  = 1'b1;
          ad_drv = wr_q[0];
        end else begin
          ad_oe = 1'b0;
        end
        #1;
        if (trdy === 1'b1) begin
          if (opb_re !== (c == CMD_DRD)) strobe_bad++;
          if (opb_we !== (c == CMD_DWR)) strobe_bad++;
          if (c == CMD_DWR && opb_di !== ad_drv) strobe_bad++;
          opb_ack = ack_en && (w >= dly);
          opb_do  = do_base + 32'(k);
          w++;
          if (w > 64) begin
            obs_q.push_back(opb_addr);
            obs_q.push_back(32'hFFFF_FFFF);
            hung = 1'b1;
            done = 1'b1;
          end
        end else begin
          opb_ack = 1'b0;
          if (opb_re !== 1'b0 || opb_we !== 1'b0) strobe_bad++;
          obs_q.push_back(opb_addr);
          obs_q.push_back(32'(w));
          if (c == CMD_DRD) obs_q.push_back(ad);
          if (c == CMD_DWR) void'(wr_q.pop_front());
          done = 1'b1;
        end
        if (!hung) @(posedge clk);
      end
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] e;
    logic [31:0] o;
    rst = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (trdy !== 1'b1 || opb_re !== 1'b0 || opb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got trdy=%b re=%b we=%b exp 1 0 0",
               trdy, opb_re, opb_we);
    end
    n_tests++;
    if (opb_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr got %h exp 0", opb_addr);
    end
    n_tests++;
    if (gpio !== 7'h00 || ad !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_hiz got gpio=%h ad=%h exp 00 ffffffff",
               gpio, ad);
    end
    rst = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h0);
    mod_burst(CMD_MRD, REG_GPDDR, 4);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_regs[%0d] got %h exp %h", i, o, e);
      end
    end
  endtask

  task automatic test_mod_burst();
    logic [31:0] e;
    logic [31:0] o;
    wr_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    mod_burst(CMD_MWR, 32'h100, 4);
    n_tests++;
    if (opb_addr !== 32'h110) begin
      n_fail++;
      $display("FAIL mod_addr_inc got %h exp 00000110", opb_addr);
    end
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    mod_burst(CMD_MRD, 32'h100, 4);
    exp_q.push_back(32'h0000_0400);
    mod_burst(CMD_MRD, REG_STAT, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mod_burst[%0d] got %h exp %h", i, o, e);
      end
    end
  endtask

  task automatic test_sp_wrap();
    logic [31:0] e;
    logic [31:0] o;
    wr_q = '{32'hA5A5_A5A5, 32'h5A5A_5A5A};
    mod_burst(CMD_MWR, 32'h13C, 2);
    wr_q = '{32'hFFFF_0000};
    mod_burst(CMD_MWR, 32'h500, 1);
    exp_q.push_back(32'hA5A5_A5A5);
    exp_q.push_back(32'h5A5A_5A5A);
    mod_burst(CMD_MRD, 32'h13C, 2);
    exp_q.push_back(32'h5A5A_5A5A);
    mod_burst(CMD_MRD, 32'h100, 1);
    exp_q.push_back(32'h0);
    mod_burst(CMD_MRD, 32'h500, 1);
    exp_q.push_back(32'h0);
    mod_burst(CMD_MRD, 32'h010, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sp_wrap[%0d] got %h exp %h", i, o, e);
      end
    end
  endtask

  task automatic test_master_abort();
    logic [31:0] o;
    addr_phase(CMD_MWR, 32'h100);
    @(negedge clk);
    frame  = 1'b1;
    irdy   = 1'b1;
    ad_drv = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (trdy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_trdy got %b exp 1", trdy);
    end
    bus_idle();
    exp_q.push_back(32'h5A5A_5A5A);
    mod_burst(CMD_MRD, 32'h100, 1);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'h0;
    n_tests++;
    if (o !== exp_q[0]) begin
      n_fail++;
      $display("FAIL abort_nowrite got %h exp %h", o, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_dev_read();
    logic [31:0] e;
    logic [31:0] o;
    int dly;
    dly = 3;
    strobe_bad = 0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h2000 + 32'(4 * k));
      exp_q.push_back(32'(dly + 1));
      exp_q.push_back(32'h1234_5678 + 32'(k));
    end
    dev_burst(CMD_DRD, 32'h2000, 2, 1'b1, dly, 32'h1234_5678);
    n_tests++;
    if (strobe_bad != 0 || opb_addr !== 32'h2008) begin
      n_fail++;
      $display("FAIL dev_rd_strobe got bad=%0d addr=%h exp 0 00002008",
               strobe_bad, opb_addr);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL dev_read[%0d] got %h exp %h", i, o, e);
      end
    end
  endtask

  task automatic test_dev_timeout();
    logic [31:0] e;
    logic [31:0] o;
    strobe_bad = 0;
    wr_q = '{32'hCAFE_F00D};
    exp_q.push_back(32'h3000);
    exp_q.push_back(32'(TO));
    dev_burst(CMD_DWR, 32'h3000, 1, 1'b0, 0, 32'h0);
    n_tests++;
    if (strobe_bad != 0) begin
      n_fail++;
      $display("FAIL dev_wr_strobe got bad=%0d exp 0", strobe_bad);
    end
    exp_q.push_back(32'h0000_0101);
    mod_burst(CMD_MRD, REG_STAT, 1);
    wr_q = '{32'h1};
    mod_burst(CMD_MWR, REG_STAT, 1);
    exp_q.push_back(32'h0000_0100);
    mod_burst(CMD_MRD, REG_STAT, 1);
    exp_q.push_back(32'h3100);
    exp_q.push_back(32'(TO));
    exp_q.push_back(32'h0BAD_CAFE);
    dev_burst(CMD_DRD, 32'h3100, 1, 1'b1, TO - 1, 32'h0BAD_CAFE);
    exp_q.push_back(32'h0000_0100);
    mod_burst(CMD_MRD, REG_STAT, 1);
    exp_q.push_back(32'h3200);
    exp_q.push_back(32'(TO));
    exp_q.push_back(32'hDEAD_BEEF);
    dev_burst(CMD_DRD, 32'h3200, 1, 1'b0, 0, 32'h1111_1111);
    exp_q.push_back(32'h0000_0101);
    mod_burst(CMD_MRD, REG_STAT, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL dev_timeout[%0d] got %h exp %h", i, o, e);
      end
    end
  endtask

  task automatic test_ignored_cmd();
    addr_phase(4'h3, 32'h100);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ad_oe = 1'b0;
      irdy  = 1'b0;
      #1;
      n_tests++;
      if (trdy !== 1'b1 || ad !== 32'hFFFF_FFFF
          || opb_re !== 1'b0 || opb_we !== 1'b0) begin
        n_fail++;
        $display("FAIL ignored_cmd[%0d] got trdy=%b ad=%h re=%b we=%b",
                 k, trdy, ad, opb_re, opb_we);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_gpio_reset();
    logic [31:0] e;
    logic [31:0] o;
    wr_q = '{32'h7F, 32'h55};
    mod_burst(CMD_MWR, REG_GPDDR, 2);
    #1;
    n_tests++;
    if (gpio !== 7'h55) begin
      n_fail++;
      $display("FAIL gpio_drive got %h exp 55", gpio);
    end
    exp_q.push_back(32'h7F);
    exp_q.push_back(32'h55);
    mod_burst(CMD_MRD, REG_GPDDR, 2);
    addr_phase(CMD_MWR, 32'h100);
    @(negedge clk);
    irdy   = 1'b0;
    ad_drv = 32'h11;
    @(posedge clk);
    @(negedge clk);
    ad_drv = 32'h22;
    rst    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (gpio !== 7'h00 || trdy !== 1'b1 || opb_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset got gpio=%h trdy=%b addr=%h exp 00 1 0",
               gpio, trdy, opb_addr);
    end
    bus_idle();
    rst = 1'b0;
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h2);
    mod_burst(CMD_MRD, 32'h100, 2);
    exp_q.push_back(32'h0);
    mod_burst(CMD_MRD, REG_GPDDR, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL gpio_reset[%0d] got %h exp %h", i, o, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mod_burst();
    test_sp_wrap();
    test_master_abort();
    test_dev_read();
    test_dev_timeout();
    test_ignored_cmd();
    test_gpio_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
